// File: rtl/ecg_nn_pkg.sv
// Shared constants and encodings for the ECG neural-network datapath blocks.
package ecg_nn_pkg;

  localparam int N_IN_DEF    = 15;
  localparam int FLOAT_W_DEF = 32;

  localparam logic [31:0] FP_ZERO = 32'd0;

  typedef enum logic {
    FILL    = 1'b0,
    DISCARD = 1'b1
  } fill_state_t;

endpackage

// File: rtl/layer6_act_buffer_act_bank.sv
// One activation bank: N_IN words, single write port, zero-fill above an index,
// and a flattened read port feeding the node inputs A0..A(N_IN-1).
module act_bank
  import ecg_nn_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int FLOAT_W = FLOAT_W_DEF,
  parameter int IDX_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    zfill,
  input  logic [IDX_W-1:0]        idx,
  input  logic [FLOAT_W-1:0]      wdata,
  output logic [N_IN*FLOAT_W-1:0] rdata
);

  logic [FLOAT_W-1:0] mem [N_IN];

  // zfill clears every word above idx, so a short frame is padded in the same cycle it closes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) begin
        mem[k] <= FLOAT_W'(FP_ZERO);
      end
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (we && (idx == IDX_W'(k))) begin
          mem[k] <= wdata;
        end else if (zfill && (IDX_W'(k) > idx)) begin
          mem[k] <= FLOAT_W'(FP_ZERO);
        end
      end
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_rd
    assign rdata[g*FLOAT_W +: FLOAT_W] = mem[g];
  end

endmodule

// File: rtl/layer6_act_buffer.sv
// Double-buffered serial-to-parallel activation collector for the layer-6 nodes.
// Define LAYER6_ACT_BUF_RELU_EN to clamp negative input words to +0.0 on write.
module layer6_act_buffer
  import ecg_nn_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int FLOAT_W = FLOAT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [FLOAT_W-1:0]      in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [N_IN*FLOAT_W-1:0] out_data,
  input  logic                    out_ready,
  output logic                    err_short,
  output logic                    err_long
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_IN - 1);

  fill_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0] bank_full, full_next;
  logic wr_bank, rd_bank;
  logic accept, drain;
  logic fill_we, close_evt, short_evt, long_evt;
  logic [FLOAT_W-1:0] wdata;
  logic [N_IN*FLOAT_W-1:0] rdata0, rdata1;

  assign in_ready  = !rst && ((state == DISCARD) || !bank_full[wr_bank]);
  assign accept    = in_valid && in_ready;
  assign out_valid = bank_full[rd_bank];
  assign drain     = out_valid && out_ready;
  assign out_data  = rd_bank ? rdata1 : rdata0;

`ifdef LAYER6_ACT_BUF_RELU_EN
  assign wdata = in_data[FLOAT_W-1] ? FLOAT_W'(FP_ZERO) : in_data;
`else
  assign wdata = in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Frame framing: the word at LAST_IDX always closes the bank; in_last decides short/long/normal
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    fill_we    = 1'b0;
    close_evt  = 1'b0;
    short_evt  = 1'b0;
    long_evt   = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          fill_we = 1'b1;
          if (cnt == LAST_IDX) begin
            close_evt = 1'b1;
            cnt_next  = '0;
            if (!in_last) begin
              long_evt   = 1'b1;
              state_next = DISCARD;
            end
          end else if (in_last) begin
            close_evt = 1'b1;
            short_evt = 1'b1;
            cnt_next  = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      DISCARD: begin
        if (accept && in_last) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Close and drain always target different banks, so both updates can apply together
  always_comb begin
    full_next = bank_full;
    if (close_evt) full_next[wr_bank] = 1'b1;
    if (drain)     full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      bank_full <= full_next;
      err_short <= short_evt;
      err_long  <= long_evt;
      if (close_evt) wr_bank <= ~wr_bank;
      if (drain)     rd_bank <= ~rd_bank;
    end
  end

  act_bank #(.N_IN(N_IN), .FLOAT_W(FLOAT_W), .IDX_W(CNT_W)) bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (fill_we && !wr_bank),
    .zfill (short_evt && !wr_bank),
    .idx   (cnt),
    .wdata (wdata),
    .rdata (rdata0)
  );

  act_bank #(.N_IN(N_IN), .FLOAT_W(FLOAT_W), .IDX_W(CNT_W)) bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (fill_we && wr_bank),
    .zfill (short_evt && wr_bank),
    .idx   (cnt),
    .wdata (wdata),
    .rdata (rdata1)
  );

endmodule

// File: tb/tb_layer6_act_buffer.sv
// Directed self-checking bench for layer6_act_buffer: framing, double buffering,
// short/long frame handling, optional ReLU and mid-frame reset.
module tb_layer6_act_buffer;

  localparam int N  = 15;
  localparam int W  = 32;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [VW-1:0] out_data;
  logic          out_ready;
  logic          err_short;
  logic          err_long;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  layer6_act_buffer #(.N_IN(N), .FLOAT_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err_short (err_short),
    .err_long  (err_long)
  );

  task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, VW'(obs), VW'(exp));
  endtask

  // Holds in_valid until the beat is taken, then releases it one cycle later
  task automatic applyStimulus(input logic [W-1:0] d, input logic l);
    int tries = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && tries < 100) begin
      @(posedge clk); #1;
      tries++;
    end
    if (tries >= 100) checkBit("handshake_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic sendFrame(input logic [W-1:0] base, input logic [W-1:0] step,
                           input int n, input int last_at);
    for (int k = 0; k < n; k++) begin
      applyStimulus(base + W'(k) * step, k == last_at);
    end
  endtask

  function automatic logic [VW-1:0] mkVec(input logic [W-1:0] base, input logic [W-1:0] step,
                                          input int n);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      if (k < n) v[k*W +: W] = base + W'(k) * step;
    end
    return v;
  endfunction

  task automatic pulseOutReady();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [VW-1:0] exp_v;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    checkBit("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkBit("reset_in_ready", in_ready, 1'b1);
    checkBit("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_out_data", out_data, '0);
    checkBit("reset_err_short", err_short, 1'b0);
    checkBit("reset_err_long", err_long, 1'b0);

    // Basic frame of 1.0 with consumer always ready
    out_ready = 1'b1;
    sendFrame(32'h3F800000, 32'd0, 14, -1);
    checkBit("f1_not_yet_valid", out_valid, 1'b0);
    applyStimulus(32'h3F800000, 1'b1);
    checkBit("f1_valid", out_valid, 1'b1);
    checkOutput("f1_data", out_data, mkVec(32'h3F800000, 32'd0, 15));
    checkBit("f1_no_short", err_short, 1'b0);
    checkBit("f1_no_long", err_long, 1'b0);
    @(posedge clk); #1;
    checkBit("f1_drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Three back-to-back frames with a stalled consumer
    sendFrame(32'h40000000, 32'd1, 15, 14);
    sendFrame(32'h40100000, 32'd1, 15, 14);
    checkBit("both_full_in_ready", in_ready, 1'b0);
    checkOutput("fa_data", out_data, mkVec(32'h40000000, 32'd1, 15));
    pulseOutReady();
    checkBit("after_drain_in_ready", in_ready, 1'b1);
    checkBit("fb_valid", out_valid, 1'b1);
    checkOutput("fb_data", out_data, mkVec(32'h40100000, 32'd1, 15));
    sendFrame(32'h40200000, 32'd1, 15, 14);
    checkOutput("fb_held", out_data, mkVec(32'h40100000, 32'd1, 15));
    pulseOutReady();
    checkOutput("fc_data", out_data, mkVec(32'h40200000, 32'd1, 15));
    pulseOutReady();
    checkBit("all_drained", out_valid, 1'b0);

    // Short frame of 4 words lands in a bank that held a full frame
    sendFrame(32'h41000000, 32'd1, 4, 3);
    checkBit("short_pulse", err_short, 1'b1);
    checkBit("short_no_long", err_long, 1'b0);
    checkBit("short_valid", out_valid, 1'b1);
    checkOutput("short_data", out_data, mkVec(32'h41000000, 32'd1, 4));
    @(posedge clk); #1;
    checkBit("short_pulse_end", err_short, 1'b0);
    pulseOutReady();

    // Long frame: 18 words, in_last only on the last
    sendFrame(32'h42000000, 32'd1, 15, -1);
    checkBit("long_pulse", err_long, 1'b1);
    checkBit("long_no_short", err_short, 1'b0);
    checkBit("long_valid", out_valid, 1'b1);
    checkOutput("long_data", out_data, mkVec(32'h42000000, 32'd1, 15));
    for (int j = 0; j < 3; j++) begin
      checkBit("discard_in_ready", in_ready, 1'b1);
      applyStimulus(32'h43000000 + W'(j), j == 2);
      if (j == 0) checkBit("long_pulse_end", err_long, 1'b0);
    end
    checkOutput("long_held", out_data, mkVec(32'h42000000, 32'd1, 15));
    pulseOutReady();
    checkBit("long_drained", out_valid, 1'b0);

    // Next frame starts from index 0 and carries -0.5 at index 3
    for (int k = 0; k < 15; k++) begin
      applyStimulus((k == 3) ? 32'hBF000000 : 32'h44000000 + W'(k), k == 14);
    end
    exp_v = mkVec(32'h44000000, 32'd1, 15);
`ifdef LAYER6_ACT_BUF_RELU_EN
    exp_v[3*W +: W] = 32'd0;
`else
    exp_v[3*W +: W] = 32'hBF000000;
`endif
    checkBit("relu_valid", out_valid, 1'b1);
    checkOutput("relu_data", out_data, exp_v);
    checkBit("relu_no_short", err_short, 1'b0);

    // Reset mid-frame while a frame is also held
    sendFrame(32'h45000000, 32'd1, 7, -1);
    rst = 1'b1;
    #1;
    checkBit("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkBit("postrst_out_valid", out_valid, 1'b0);
    checkOutput("postrst_out_data", out_data, '0);
    checkBit("postrst_in_ready", in_ready, 1'b1);
    checkBit("postrst_err_short", err_short, 1'b0);
    checkBit("postrst_err_long", err_long, 1'b0);
    sendFrame(32'h46000000, 32'd1, 15, 14);
    checkBit("postrst_frame_valid", out_valid, 1'b1);
    checkOutput("postrst_frame_data", out_data, mkVec(32'h46000000, 32'd1, 15));
    checkBit("postrst_frame_no_short", err_short, 1'b0);
    checkBit("postrst_frame_no_long", err_long, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
